// File: rtl/sar_search_4b_pkg.sv
// Shared types and constants for the successive-approximation search controller.
// The comparator result is one-hot {gt, eq, lt}, seen from the target's side.
package sar_search_4b_pkg;

   typedef enum logic [1:0] {
      IDLE,
      TEST,
      VERIFY,
      DONE
   } sar_state_t;

   typedef logic [2:0] cmp_t;

   localparam cmp_t CMP_GT = 3'b100;
   localparam cmp_t CMP_EQ = 3'b010;
   localparam cmp_t CMP_LT = 3'b001;

   // True only for one of the three legal comparator encodings.
   function automatic logic is_one_hot(input cmp_t v);
      return (v == CMP_GT) || (v == CMP_EQ) || (v == CMP_LT);
   endfunction

endpackage

// File: rtl/sar_search_4b_if.sv
// Controller-to-comparator bundle. The master side is the search controller,
// which owns guess and the status outputs; the slave side is the environment
// that supplies start and the comparator result.
interface sar_search_4b_if
   import sar_search_4b_pkg::*;
#(
   parameter int WIDTH = 4
);
   logic             start;
   cmp_t             cmp_res;
   logic [WIDTH-1:0] guess;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             found;
   logic             err;

   modport master (
      input  start, cmp_res,
      output guess, busy, done, result, found, err
   );

   modport slave (
      output start, cmp_res,
      input  guess, busy, done, result, found, err
   );

endinterface

// File: rtl/sar_search_4b.sv
// Successive-approximation search: walks guess from the MSB down, keeping or
// clearing each bit from the comparator's verdict, exits early on equality,
// and confirms the final all-bits-decided value with one extra compare.
module sar_search_4b
   import sar_search_4b_pkg::*;
#(
   parameter int WIDTH = 4
)
(
   input logic             clk,
   input logic             rst,
   sar_search_4b_if.master bus
);

   localparam int               IDX_W      = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] GUESS_INIT = {1'b1, {(WIDTH-1){1'b0}}};

   sar_state_t       state, state_nxt;
   logic [WIDTH-1:0] guess, guess_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [WIDTH-1:0] result, result_nxt;
   logic             found, found_nxt;
   logic             err, err_nxt;
   logic             busy, busy_nxt;
   logic [WIDTH-1:0] trial;
   logic [IDX_W-1:0] idx_m1;

   // State and datapath registers; reset aborts any search without a done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         guess  <= '0;
         idx    <= '0;
         result <= '0;
         found  <= 1'b0;
         err    <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_nxt;
         guess  <= guess_nxt;
         idx    <= idx_nxt;
         result <= result_nxt;
         found  <= found_nxt;
         err    <= err_nxt;
         busy   <= busy_nxt;
      end
   end

   // Next-state and bit-decision logic; every register holds unless a state acts on it.
   always_comb begin
      state_nxt  = state;
      guess_nxt  = guess;
      idx_nxt    = idx;
      result_nxt = result;
      found_nxt  = found;
      err_nxt    = err;
      busy_nxt   = busy;
      trial      = guess;
      idx_m1     = idx - 1'b1;

      case (state)
         IDLE: begin
            if (bus.start) begin
               guess_nxt  = GUESS_INIT;
               idx_nxt    = IDX_TOP;
               result_nxt = '0;
               found_nxt  = 1'b0;
               err_nxt    = 1'b0;
               busy_nxt   = 1'b1;
               state_nxt  = TEST;
            end
         end

         TEST: begin
            if (!is_one_hot(bus.cmp_res)) begin
               err_nxt    = 1'b1;
               found_nxt  = 1'b0;
               result_nxt = guess;
               state_nxt  = DONE;
            end else if (bus.cmp_res == CMP_EQ) begin
               result_nxt = guess;
               found_nxt  = 1'b1;
               state_nxt  = DONE;
            end else begin
               if (bus.cmp_res == CMP_LT) begin
                  trial[idx] = 1'b0;
               end
               if (idx != '0) begin
                  trial[idx_m1] = 1'b1;
                  idx_nxt       = idx_m1;
               end else begin
                  state_nxt = VERIFY;
               end
               guess_nxt = trial;
            end
         end

         VERIFY: begin
            found_nxt  = (bus.cmp_res == CMP_EQ);
            err_nxt    = !is_one_hot(bus.cmp_res);
            result_nxt = guess;
            state_nxt  = DONE;
         end

         DONE: begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.guess  = guess;
   assign bus.busy   = busy;
   assign bus.done   = (state == DONE);
   assign bus.result = result;
   assign bus.found  = found;
   assign bus.err    = err;

endmodule

// File: tb/tb_sar_search_4b.sv
// Directed bench for the SAR search controller: a behavioural 4-bit magnitude
// comparator closes the loop (A = target, B = guess), with an override to inject
// corrupted comparator results on a chosen cycle.
module tb_sar_search_4b;

   localparam int WIDTH = 4;

   typedef struct {
      logic [3:0]  target;
      int          faultCycle;
      logic [2:0]  faultVal;
      logic [19:0] seq;
      int          doneCycle;
      logic [3:0]  result;
      logic        found;
      logic        err;
   } vec_t;

   localparam int NVEC = 12;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  target;
   logic        forceEn;
   logic [2:0]  forceVal;
   logic [2:0]  cmpModel;
   int          testsRun = 0;
   int          testsFailed = 0;
   logic [19:0] logSeq;
   int          doneCycle;
   logic        busyAtStart;
   int          gap;
   int          expK;
   int          lowBit;
   logic        sawDone;
   vec_t        vecs [NVEC];

   sar_search_4b_if #(.WIDTH(WIDTH)) bus ();

   sar_search_4b #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Reference comparator: target versus the controller's current guess.
   always_comb begin
      if (target > bus.guess)       cmpModel = 3'b100;
      else if (target == bus.guess) cmpModel = 3'b010;
      else                          cmpModel = 3'b001;
   end

   assign bus.cmp_res = forceEn ? forceVal : cmpModel;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Pulses start for one cycle, then logs each guess shown before done rises.
   // Cycle 1 is the first cycle after start is accepted; the comparator is
   // overridden for the whole of cycle faultCycle when it is non-zero.
   task automatic applyStimulus(input logic [3:0] tgt, input int faultCycle, input logic [2:0] faultVal);
      target    = tgt;
      logSeq    = '0;
      doneCycle = 0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start   = 1'b0;
      busyAtStart = bus.busy;
      for (int c = 1; c <= 20 && doneCycle == 0; c++) begin
         if (bus.done) begin
            doneCycle = c;
         end else begin
            logSeq   = {logSeq[15:0], bus.guess};
            forceEn  = (c == faultCycle);
            forceVal = faultVal;
            @(negedge clk);
         end
      end
      forceEn = 1'b0;
      if (doneCycle == 0) begin
         checkOutput("search timeout", 32'd0, 32'd1);
      end
   endtask

   initial begin
      vecs[0]  = '{4'hB, 0, 3'b000, 20'h08CAB, 5, 4'hB, 1'b1, 1'b0};
      vecs[1]  = '{4'h8, 0, 3'b000, 20'h00008, 2, 4'h8, 1'b1, 1'b0};
      vecs[2]  = '{4'h0, 0, 3'b000, 20'h84210, 6, 4'h0, 1'b1, 1'b0};
      vecs[3]  = '{4'hF, 0, 3'b000, 20'h08CEF, 5, 4'hF, 1'b1, 1'b0};
      vecs[4]  = '{4'h7, 0, 3'b000, 20'h08467, 5, 4'h7, 1'b1, 1'b0};
      vecs[5]  = '{4'h9, 0, 3'b000, 20'h08CA9, 5, 4'h9, 1'b1, 1'b0};
      vecs[6]  = '{4'hE, 0, 3'b000, 20'h008CE, 4, 4'hE, 1'b1, 1'b0};
      vecs[7]  = '{4'h4, 0, 3'b000, 20'h00084, 3, 4'h4, 1'b1, 1'b0};
      vecs[8]  = '{4'hD, 2, 3'b011, 20'h0008C, 3, 4'hC, 1'b0, 1'b1};
      vecs[9]  = '{4'h0, 5, 3'b000, 20'h84210, 6, 4'h0, 1'b0, 1'b1};
      vecs[10] = '{4'h0, 5, 3'b100, 20'h84210, 6, 4'h0, 1'b0, 1'b0};
      vecs[11] = '{4'h3, 1, 3'b111, 20'h00008, 2, 4'h8, 1'b0, 1'b1};

      rst       = 1'b1;
      bus.start = 1'b0;
      target    = 4'h0;
      forceEn   = 1'b0;
      forceVal  = 3'b000;

      // Reset state.
      #12;
      checkOutput("reset guess",  32'(bus.guess),  32'h0);
      checkOutput("reset result", 32'(bus.result), 32'h0);
      checkOutput("reset busy",   32'(bus.busy),   32'h0);
      checkOutput("reset done",   32'(bus.done),   32'h0);
      checkOutput("reset found",  32'(bus.found),  32'h0);
      checkOutput("reset err",    32'(bus.err),    32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Table-driven searches, including injected comparator faults.
      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i].target, vecs[i].faultCycle, vecs[i].faultVal);
         checkOutput($sformatf("v%0d busy on first cycle", i), 32'(busyAtStart), 32'h1);
         checkOutput($sformatf("v%0d done cycle", i), 32'(doneCycle), 32'(vecs[i].doneCycle));
         checkOutput($sformatf("v%0d guess sequence", i), 32'(logSeq), 32'(vecs[i].seq));
         checkOutput($sformatf("v%0d result", i), 32'(bus.result), 32'(vecs[i].result));
         checkOutput($sformatf("v%0d found", i), 32'(bus.found), 32'(vecs[i].found));
         checkOutput($sformatf("v%0d err", i), 32'(bus.err), 32'(vecs[i].err));
         checkOutput($sformatf("v%0d busy in done cycle", i), 32'(bus.busy), 32'h1);
         @(negedge clk);
         checkOutput($sformatf("v%0d done single pulse", i), 32'(bus.done), 32'h0);
         checkOutput($sformatf("v%0d busy after done", i), 32'(bus.busy), 32'h0);
         checkOutput($sformatf("v%0d result held", i), 32'(bus.result), 32'(vecs[i].result));
      end

      // Asynchronous reset in the third search cycle aborts without a done pulse.
      target = 4'hB;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("async rst guess",  32'(bus.guess),  32'h0);
      checkOutput("async rst result", 32'(bus.result), 32'h0);
      checkOutput("async rst busy",   32'(bus.busy),   32'h0);
      checkOutput("async rst done",   32'(bus.done),   32'h0);
      checkOutput("async rst found",  32'(bus.found),  32'h0);
      checkOutput("async rst err",    32'(bus.err),    32'h0);
      sawDone = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (bus.done) sawDone = 1'b1;
      end
      rst = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done) sawDone = 1'b1;
      end
      checkOutput("no done after abort", 32'(sawDone), 32'h0);
      applyStimulus(4'h5, 0, 3'b000);
      checkOutput("post-reset done cycle", 32'(doneCycle), 32'd5);
      checkOutput("post-reset sequence", 32'(logSeq), 32'h08465);
      checkOutput("post-reset result", 32'(bus.result), 32'h5);
      checkOutput("post-reset found", 32'(bus.found), 32'h1);
      @(negedge clk);

      // Exhaustive sweep with start held high: back-to-back searches, each
      // accepted on the IDLE cycle after done. A target whose lowest set bit is
      // p matches on search cycle 4-p, so done lands on cycle 5-p; target 0
      // needs all four bit tests, a verify cycle and then done (cycle 6).
      target = 4'h0;
      @(negedge clk);
      bus.start = 1'b1;
      for (int t = 0; t < 16; t++) begin
         lowBit = 4;
         for (int b = 3; b >= 0; b--) begin
            if (t[b]) lowBit = b;
         end
         expK = (t == 0) ? 6 : (5 - lowBit);
         if (t != 0) expK = expK + 1;
         gap     = 0;
         sawDone = 1'b0;
         while (!sawDone && gap < 20) begin
            @(negedge clk);
            gap++;
            if (bus.done) sawDone = 1'b1;
         end
         checkOutput($sformatf("sweep t=%0d cycles", t), 32'(gap), 32'(expK));
         checkOutput($sformatf("sweep t=%0d result", t), 32'(bus.result), 32'(t));
         checkOutput($sformatf("sweep t=%0d found", t), 32'(bus.found), 32'h1);
         checkOutput($sformatf("sweep t=%0d err", t), 32'(bus.err), 32'h0);
         target = 4'(t + 1);
      end
      bus.start = 1'b0;
      repeat (8) @(negedge clk);
      checkOutput("idle after sweep busy", 32'(bus.busy), 32'h0);
      checkOutput("idle after sweep done", 32'(bus.done), 32'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
